// File: rtl/race_pkg.sv
// Shared constants and types for the race timer: game-state codes and the packed BCD time word.
package race_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETTING   = 3'd1;
    localparam logic [2:0] COUNTDOWN = 3'd3;
    localparam logic [2:0] RACING    = 3'd4;
    localparam logic [2:0] PAUSE     = 3'd5;
    localparam logic [2:0] FINISH    = 3'd6;

    localparam int                    BCD_TIME_W   = 20;
    localparam logic [BCD_TIME_W-1:0] BCD_TIME_MAX = 20'h95999;

    // m:ss.cc, most significant digit first so the packed word compares like a time.
    typedef struct packed {
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
        logic [3:0] cs_t;
        logic [3:0] cs_o;
    } bcd_time_t;

    function automatic logic is_clear_state(input logic [2:0] s);
        return (s == IDLE) || (s == SETTING) || (s == COUNTDOWN);
    endfunction

endpackage

// File: rtl/race_timer_bcd_time_counter.sv
// Saturating m:ss.cc BCD counter; carries ripple through all digits in one cycle.
module bcd_time_counter
    import race_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [BCD_TIME_W-1:0] q,
    output logic                  sat
);

    bcd_time_t cnt;
    bcd_time_t cnt_next;

    assign q   = cnt;
    assign sat = (cnt == BCD_TIME_MAX);

    always_comb begin
        // NOTE: default assignment first, so every path drives cnt_next and no latch is inferred.
        cnt_next = cnt;
        if (inc && !sat) begin
            if (cnt.cs_o != 4'd9) begin
                cnt_next.cs_o = cnt.cs_o + 4'd1;
            end else begin
                cnt_next.cs_o = 4'd0;
                if (cnt.cs_t != 4'd9) begin
                    cnt_next.cs_t = cnt.cs_t + 4'd1;
                end else begin
                    cnt_next.cs_t = 4'd0;
                    if (cnt.sec_o != 4'd9) begin
                        cnt_next.sec_o = cnt.sec_o + 4'd1;
                    end else begin
                        cnt_next.sec_o = 4'd0;
                        if (cnt.sec_t != 4'd5) begin
                            cnt_next.sec_t = cnt.sec_t + 4'd1;
                        end else begin
                            // min_o cannot be 9 here: that case is the saturated value.
                            cnt_next.sec_t = 4'd0;
                            cnt_next.min_o = cnt.min_o + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/race_timer.sv
// Race clock and lap bookkeeping. Optional best-lap tracking is built when RACE_TIMER_BEST_LAP_EN is defined.
module race_timer
    import race_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 100,
    parameter int TOTAL_LAPS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  state,
    input  logic        lap_pulse,
    output logic [19:0] race_time,
    output logic [19:0] lap_time,
    output logic [19:0] last_lap_time,
    output logic [19:0] best_lap_time,
    output logic [3:0]  lap_count,
    output logic        is_game_end,
    output logic        time_ovf
);

    localparam int               DIV      = CLK_HZ / TICK_HZ;
    localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [3:0]       LAPS     = 4'(TOTAL_LAPS);

    logic [PRE_W-1:0] prescaler;
    logic             racing;
    logic             clear;
    logic             tick;
    logic             lap_hit;
    logic             race_inc;
    logic             race_sat;
    logic             lap_inc;
    logic             lap_clr;
    logic             lap_sat;

    assign racing   = (state == RACING);
    assign clear    = is_clear_state(state);
    assign tick     = racing && (prescaler == PRE_LAST);
    assign lap_hit  = racing && lap_pulse && (lap_count < LAPS);
    assign race_inc = tick && !is_game_end;
    // A lap restart wins over a coincident tick, so the new lap starts at zero.
    assign lap_clr  = clear || lap_hit;
    assign lap_inc  = tick && !lap_sat;

    // PAUSE and undefined codes fall through and hold, so a resumed race continues mid-tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (clear) begin
            prescaler <= '0;
        end else if (racing) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

    bcd_time_counter u_race (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (race_inc),
        .q     (race_time),
        .sat   (race_sat)
    );

    bcd_time_counter u_lap (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lap_clr),
        .inc   (lap_inc),
        .q     (lap_time),
        .sat   (lap_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_lap_time <= '0;
            lap_count     <= '0;
            is_game_end   <= 1'b0;
            time_ovf      <= 1'b0;
        end else if (clear) begin
            last_lap_time <= '0;
            lap_count     <= '0;
            is_game_end   <= 1'b0;
            time_ovf      <= 1'b0;
        end else begin
            if (lap_hit) begin
                last_lap_time <= lap_time;
                lap_count     <= lap_count + 4'd1;
                if (lap_count == LAPS - 4'd1) begin
                    is_game_end <= 1'b1;
                end
            end
            if (race_inc && race_sat) begin
                time_ovf <= 1'b1;
            end
        end
    end

`ifdef RACE_TIMER_BEST_LAP_EN
    logic [19:0] best_q;

    // Packed BCD orders like the time it encodes, so a plain unsigned compare is enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= BCD_TIME_MAX;
        end else if (lap_hit && (lap_time < best_q)) begin
            best_q <= lap_time;
        end
    end

    assign best_lap_time = best_q;
`else
    assign best_lap_time = '0;
`endif

endmodule

// File: tb/tb_race_timer.sv
// Randomized scoreboard bench for race_timer against a centisecond-integer reference model.
module tb_race_timer;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int LAPS    = 2;
    localparam int MAX_CS  = 59999;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETTING   = 3'd1;
    localparam logic [2:0] S_COUNTDOWN = 3'd3;
    localparam logic [2:0] S_RACING    = 3'd4;
    localparam logic [2:0] S_PAUSE     = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

`ifdef RACE_TIMER_BEST_LAP_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif
    localparam logic [19:0] BEST_RST = BEST_EN ? 20'h95999 : 20'h0;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic [2:0]  state, state2;
    logic        lap_pulse, lap_pulse2;
    logic [19:0] race_time, lap_time, last_lap_time, best_lap_time;
    logic [3:0]  lap_count;
    logic        is_game_end, time_ovf;
    logic [19:0] race2, lap2, last2, best2;
    logic [3:0]  count2;
    logic        end2, ovf2;

    int checks   = 0;
    int failures = 0;
    bit done2    = 1'b0;

    typedef struct {
        logic [19:0] race;
        logic [19:0] lap;
        logic [19:0] last;
        logic [19:0] best;
        logic [3:0]  count;
        logic        ended;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];

    int m_race, m_lap, m_last, m_best, m_count, m_pre;
    bit m_end, m_ovf;

    always #5 clk = ~clk;

    race_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .TOTAL_LAPS(LAPS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .lap_pulse     (lap_pulse),
        .race_time     (race_time),
        .lap_time      (lap_time),
        .last_lap_time (last_lap_time),
        .best_lap_time (best_lap_time),
        .lap_count     (lap_count),
        .is_game_end   (is_game_end),
        .time_ovf      (time_ovf)
    );

    // One tick per clock, so saturation is reachable in about 60k cycles.
    race_timer #(.CLK_HZ(100), .TICK_HZ(100), .TOTAL_LAPS(LAPS)) dut_fast (
        .clk           (clk),
        .rst_n         (rst2_n),
        .state         (state2),
        .lap_pulse     (lap_pulse2),
        .race_time     (race2),
        .lap_time      (lap2),
        .last_lap_time (last2),
        .best_lap_time (best2),
        .lap_count     (count2),
        .is_game_end   (end2),
        .time_ovf      (ovf2)
    );

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_reset();
        m_race = 0; m_lap = 0; m_last = 0; m_count = 0; m_pre = 0;
        m_end = 1'b0; m_ovf = 1'b0;
        m_best = BEST_EN ? MAX_CS : 0;
    endtask

    task automatic model_step(input logic [2:0] st, input logic lp);
        bit tk, hit;
        if (st == S_IDLE || st == S_SETTING || st == S_COUNTDOWN) begin
            m_race = 0; m_lap = 0; m_last = 0; m_count = 0; m_pre = 0;
            m_end = 1'b0; m_ovf = 1'b0;
        end else if (st == S_RACING) begin
            tk    = (m_pre == DIV - 1);
            m_pre = tk ? 0 : m_pre + 1;
            hit   = lp && (m_count < LAPS);
            if (tk && !m_end) begin
                if (m_race == MAX_CS) m_ovf = 1'b1;
                else                  m_race++;
            end
            if (hit) begin
                if (BEST_EN && m_lap < m_best) m_best = m_lap;
                m_last = m_lap;
                m_lap  = 0;
                m_count++;
                if (m_count == LAPS) m_end = 1'b1;
            end else if (tk && m_lap < MAX_CS) begin
                m_lap++;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.race  = to_bcd(m_race);
        e.lap   = to_bcd(m_lap);
        e.last  = to_bcd(m_last);
        e.best  = BEST_EN ? to_bcd(m_best) : 20'h0;
        e.count = 4'(m_count);
        e.ended = m_end;
        e.ovf   = m_ovf;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] st, input logic lp);
        state     = st;
        lap_pulse = lp;
        @(posedge clk);
        model_step(st, lp);
        push_expected();
        #1;
        lap_pulse = 1'b0;
    endtask

    task automatic run(input logic [2:0] st, input int n);
        repeat (n) drive(st, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a new registered snapshot.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("race_time", race_time, e.race);
                check("lap_time", lap_time, e.lap);
                check("last_lap_time", last_lap_time, e.last);
                check("best_lap_time", best_lap_time, e.best);
                check("lap_count", 20'(lap_count), 20'(e.count));
                check("is_game_end", 20'(is_game_end), 20'(e.ended));
                check("time_ovf", 20'(time_ovf), 20'(e.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        state2     = S_RACING;
        lap_pulse2 = 1'b0;
        wait (rst2_n === 1'b1);
        for (int n = 1; n <= 60010; n++) begin
            @(posedge clk);
            #1;
            if (n == 100)   check("fast_race_1s", race2, 20'h00100);
            if (n == 6000)  check("fast_race_1min", race2, 20'h10000);
            if (n == 59998) begin
                check("fast_race_95998", race2, 20'h95998);
                check("fast_ovf_clear", 20'(ovf2), 20'h0);
            end
            if (n == 59999) begin
                check("fast_race_95999", race2, 20'h95999);
                check("fast_ovf_at_max", 20'(ovf2), 20'h0);
            end
            if (n == 60000) begin
                check("fast_race_hold", race2, 20'h95999);
                check("fast_ovf_set", 20'(ovf2), 20'h1);
            end
            if (n == 60010) begin
                check("fast_race_sat", race2, 20'h95999);
                check("fast_lap_sat", lap2, 20'h95999);
                check("fast_ovf_sticky", 20'(ovf2), 20'h1);
            end
        end
        done2 = 1'b1;
    end

    initial begin
        int guard;
        logic [2:0] st;
        int r, len;

        rst_n = 1'b0; rst2_n = 1'b0;
        state = S_IDLE; lap_pulse = 1'b0;
        model_reset();
        #3;
        check("rst_race", race_time, 20'h0);
        check("rst_lap_count", 20'(lap_count), 20'h0);
        check("rst_best", best_lap_time, BEST_RST);
        check("rst_end", 20'(is_game_end), 20'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; rst2_n = 1'b1;

        // 1000 cycles of racing: 100 ticks.
        run(S_RACING, 1000);
        check("t1_race", race_time, 20'h00100);
        check("t1_lap", lap_time, 20'h00100);

        // Pause holds the prescaler mid-tick.
        run(S_IDLE, 1);
        run(S_RACING, 55);
        check("t2_race_55", race_time, 20'h00005);
        run(S_PAUSE, 200);
        check("t2_race_pause", race_time, 20'h00005);
        run(S_RACING, 44);
        check("t2_race_44", race_time, 20'h00009);
        run(S_RACING, 1);
        check("t2_race_45", race_time, 20'h00010);

        // Two laps end the race.
        run(S_IDLE, 1);
        run(S_RACING, 2500);
        check("t3_race_250", race_time, 20'h00250);
        drive(S_RACING, 1'b1);
        check("t3_last1", last_lap_time, 20'h00250);
        check("t3_lap_zero", lap_time, 20'h0);
        check("t3_count1", 20'(lap_count), 20'h1);
        guard = 0;
        while (m_lap != 120 && guard < 3000) begin
            drive(S_RACING, 1'b0);
            guard++;
        end
        check("t3_lap_wait", lap_time, 20'h00120);
        drive(S_RACING, 1'b1);
        check("t3_last2", last_lap_time, 20'h00120);
        check("t3_count2", 20'(lap_count), 20'h2);
        check("t3_end", 20'(is_game_end), 20'h1);
        check("t3_race_370", race_time, 20'h00370);
        for (int i = 0; i < 100; i++) drive(S_RACING, 1'($urandom_range(0, 3) == 0));
        check("t3_race_frozen", race_time, 20'h00370);
        check("t3_count_hold", 20'(lap_count), 20'h2);

        // Finish holds, idle clears all but the best lap.
        run(S_FINISH, 20);
        check("t5_finish_race", race_time, 20'h00370);
        check("t5_finish_end", 20'(is_game_end), 20'h1);
        run(S_IDLE, 1);
        check("t5_idle_race", race_time, 20'h0);
        check("t5_idle_last", last_lap_time, 20'h0);
        check("t5_idle_count", 20'(lap_count), 20'h0);
        check("t5_idle_end", 20'(is_game_end), 20'h0);
        check("t5_best", best_lap_time, BEST_EN ? 20'h00120 : 20'h0);

        // Lap pulse on a tick cycle: the tick goes to race_time only.
        run(S_RACING, 39);
        check("t6_pre_lap", lap_time, 20'h00003);
        drive(S_RACING, 1'b1);
        check("t6_race", race_time, 20'h00004);
        check("t6_lap", lap_time, 20'h0);
        check("t6_last", last_lap_time, 20'h00003);

        for (int blk = 0; blk < 120; blk++) begin
            r   = $urandom_range(0, 9);
            len = $urandom_range(1, 40);
            case (r)
                6:       st = S_PAUSE;
                7:       st = S_FINISH;
                8:       st = 3'($urandom_range(0, 7));
                9:       st = ($urandom_range(0, 2) == 0) ? S_SETTING : S_COUNTDOWN;
                default: st = S_RACING;
            endcase
            for (int c = 0; c < len; c++) drive(st, 1'($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset mid-race, with a pulse present while in reset.
        run(S_IDLE, 1);
        run(S_RACING, 123);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        lap_pulse = 1'b1;
        #1;
        check("arst_race", race_time, 20'h0);
        check("arst_lap", lap_time, 20'h0);
        check("arst_best", best_lap_time, BEST_RST);
        model_reset();
        #1;
        rst_n = 1'b1;
        lap_pulse = 1'b0;
        run(S_RACING, 15);
        check("arst_after_race", race_time, 20'h00001);
        check("arst_after_count", 20'(lap_count), 20'h0);

        wait (done2);
        @(negedge clk);
        #1;
        check("sb_drained", 20'(sb_q.size()), 20'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
